// File: rtl/pulse_gen_mc.sv
// pulse_gen_mc: multi-channel pulse-train generator.
// Each channel has an independent IDLE/ACTIVE/REST state machine that produces
// 'count' pulses. Each pulse is phi+1 cycles at ~idle, followed by plow+1 cycles
// at idle.
// Optional feature: define PULSE_GEN_MC_CONT_EN to add the 'cont' port. When a
// channel latches cont=1, its train repeats until stop or reset.
//
// state  | meaning
// IDLE   | no train running; sig_o holds latched idle level
// ACTIVE | pulse phase, sig_o = ~idle for phi+1 cycles
// REST   | rest phase, sig_o = idle for plow+1 cycles
module pulse_gen_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS*WIDTH-1:0] count,
  input  logic [CHANNELS*WIDTH-1:0] phi,
  input  logic [CHANNELS*WIDTH-1:0] plow,
  input  logic [CHANNELS-1:0]       idle,
`ifdef PULSE_GEN_MC_CONT_EN
  input  logic [CHANNELS-1:0]       cont,
`endif
  output logic [CHANNELS-1:0]       sig_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS-1:0]       done_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_REST   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q   [CHANNELS];
  state_t           state_d   [CHANNELS];
  logic [WIDTH-1:0] pcnt_q    [CHANNELS];
  logic [WIDTH-1:0] pcnt_d    [CHANNELS];
  logic [WIDTH-1:0] phase_q   [CHANNELS];
  logic [WIDTH-1:0] phase_d   [CHANNELS];
  logic [WIDTH-1:0] cnt_lat_q [CHANNELS];
  logic [WIDTH-1:0] cnt_lat_d [CHANNELS];
  logic [WIDTH-1:0] phi_lat_q [CHANNELS];
  logic [WIDTH-1:0] phi_lat_d [CHANNELS];
  logic [WIDTH-1:0] plow_lat_q[CHANNELS];
  logic [WIDTH-1:0] plow_lat_d[CHANNELS];

  logic [CHANNELS-1:0] idle_lat_q, idle_lat_d;
  logic [CHANNELS-1:0] cont_lat_q, cont_lat_d;
  logic [CHANNELS-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0] busy_q, busy_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] cont_w;

`ifdef PULSE_GEN_MC_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = '0;
`endif

  // Per-channel next-state, counter and output computation.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      state_d[n]    = state_q[n];
      pcnt_d[n]     = pcnt_q[n];
      phase_d[n]    = phase_q[n];
      cnt_lat_d[n]  = cnt_lat_q[n];
      phi_lat_d[n]  = phi_lat_q[n];
      plow_lat_d[n] = plow_lat_q[n];
      idle_lat_d[n] = idle_lat_q[n];
      cont_lat_d[n] = cont_lat_q[n];
      sig_d[n]      = sig_q[n];
      busy_d[n]     = busy_q[n];
      done_d[n]     = 1'b0;

      case (state_q[n])
        S_IDLE: begin
          if (start[n] && !stop[n]) begin
            cnt_lat_d[n]  = count[n*WIDTH +: WIDTH];
            phi_lat_d[n]  = phi[n*WIDTH +: WIDTH];
            plow_lat_d[n] = plow[n*WIDTH +: WIDTH];
            cont_lat_d[n] = cont_w[n];
            if (count[n*WIDTH +: WIDTH] == '0) begin
              // Empty train: report completion, leave the output level untouched.
              done_d[n] = 1'b1;
            end else begin
              idle_lat_d[n] = idle[n];
              state_d[n]    = S_ACTIVE;
              pcnt_d[n]     = count[n*WIDTH +: WIDTH];
              phase_d[n]    = phi[n*WIDTH +: WIDTH];
              sig_d[n]      = ~idle[n];
              busy_d[n]     = 1'b1;
            end
          end
        end

        S_ACTIVE: begin
          if (stop[n]) begin
            state_d[n] = S_IDLE;
            pcnt_d[n]  = '0;
            phase_d[n] = '0;
            sig_d[n]   = idle_lat_q[n];
            busy_d[n]  = 1'b0;
          end else if (phase_q[n] == '0) begin
            state_d[n] = S_REST;
            phase_d[n] = plow_lat_q[n];
            pcnt_d[n]  = pcnt_q[n] - ONE;
            sig_d[n]   = idle_lat_q[n];
          end else begin
            phase_d[n] = phase_q[n] - ONE;
          end
        end

        S_REST: begin
          if (stop[n]) begin
            state_d[n] = S_IDLE;
            pcnt_d[n]  = '0;
            phase_d[n] = '0;
            sig_d[n]   = idle_lat_q[n];
            busy_d[n]  = 1'b0;
          end else if (phase_q[n] == '0) begin
            if (pcnt_q[n] != '0 || cont_lat_q[n]) begin
              // Next pulse; in continuous mode an exhausted counter is reloaded.
              state_d[n] = S_ACTIVE;
              phase_d[n] = phi_lat_q[n];
              sig_d[n]   = ~idle_lat_q[n];
              if (pcnt_q[n] == '0) begin
                pcnt_d[n] = cnt_lat_q[n];
              end
            end else begin
              state_d[n] = S_IDLE;
              busy_d[n]  = 1'b0;
              done_d[n]  = 1'b1;
            end
          end else begin
            phase_d[n] = phase_q[n] - ONE;
          end
        end

        default: begin
          state_d[n] = S_IDLE;
          busy_d[n]  = 1'b0;
        end
      endcase
    end
  end

  // Channel state registers; reset clears everything, including latched idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n]    <= S_IDLE;
        pcnt_q[n]     <= '0;
        phase_q[n]    <= '0;
        cnt_lat_q[n]  <= '0;
        phi_lat_q[n]  <= '0;
        plow_lat_q[n] <= '0;
      end
      idle_lat_q <= '0;
      cont_lat_q <= '0;
      sig_q      <= '0;
      busy_q     <= '0;
      done_q     <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n]    <= state_d[n];
        pcnt_q[n]     <= pcnt_d[n];
        phase_q[n]    <= phase_d[n];
        cnt_lat_q[n]  <= cnt_lat_d[n];
        phi_lat_q[n]  <= phi_lat_d[n];
        plow_lat_q[n] <= plow_lat_d[n];
      end
      idle_lat_q <= idle_lat_d;
      cont_lat_q <= cont_lat_d;
      sig_q      <= sig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sig_o  = sig_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Testbench for pulse_gen_mc. Expected outputs come from a per-channel model:
// the train start time plus modular arithmetic over the pulse period.
module tb_pulse_gen_mc;

  localparam int W = 8;
  localparam int C = 4;

  logic           clock;
  logic           reset;
  logic [C-1:0]   start, stop, idle, cont_tb;
  logic [C*W-1:0] count, phi, plow;
  logic [C-1:0]   sig_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  pulse_gen_mc #(.WIDTH(W), .CHANNELS(C)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .count  (count),
    .phi    (phi),
    .plow   (plow),
    .idle   (idle),
`ifdef PULSE_GEN_MC_CONT_EN
    .cont   (cont_tb),
`endif
    .sig_o  (sig_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  int       edge_n;
  bit       m_run  [C];
  int       m_t0   [C];
  int       m_cnt  [C];
  int       m_phi  [C];
  int       m_plow [C];
  bit       m_cont [C];
  logic [C-1:0] m_idle, m_sig, m_busy, m_done;

  task automatic model_reset();
    for (int n = 0; n < C; n++) begin
      m_run[n] = 0; m_t0[n] = 0; m_cnt[n] = 0; m_phi[n] = 0; m_plow[n] = 0; m_cont[n] = 0;
    end
    m_idle = '0; m_sig = '0; m_busy = '0; m_done = '0;
  endtask

  // The output at elapsed cycle e of a train is ~idle during the first phi+1
  // cycles of each (phi+plow+2)-cycle period. Without cont, the train ends
  // after count whole periods.
  task automatic model_edge();
    edge_n++;
    for (int n = 0; n < C; n++) begin
      int e;
      int p;
      m_done[n] = 1'b0;
      if (m_run[n]) begin
        if (stop[n]) begin
          m_run[n] = 0; m_busy[n] = 1'b0; m_sig[n] = m_idle[n];
        end else begin
          p = m_phi[n] + m_plow[n] + 2;
          e = edge_n - m_t0[n];
          if (!m_cont[n] && e == m_cnt[n] * p) begin
            m_run[n] = 0; m_busy[n] = 1'b0; m_done[n] = 1'b1; m_sig[n] = m_idle[n];
          end else begin
            m_busy[n] = 1'b1;
            m_sig[n]  = ((e % p) <= m_phi[n]) ? ~m_idle[n] : m_idle[n];
          end
        end
      end else if (start[n] && !stop[n]) begin
        if (count[n*W +: W] == 0) begin
          m_done[n] = 1'b1;
        end else begin
          m_cnt[n]  = int'(count[n*W +: W]);
          m_phi[n]  = int'(phi[n*W +: W]);
          m_plow[n] = int'(plow[n*W +: W]);
`ifdef PULSE_GEN_MC_CONT_EN
          m_cont[n] = cont_tb[n];
`else
          m_cont[n] = 1'b0;
`endif
          m_idle[n] = idle[n];
          m_t0[n]   = edge_n;
          m_run[n]  = 1;
          m_busy[n] = 1'b1;
          m_sig[n]  = ~idle[n];
        end
      end
    end
  endtask

  task automatic clear_inputs();
    start = '0; stop = '0; idle = '0; cont_tb = '0;
    count = '0; phi = '0; plow = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #23;
    checks += 3;
    if (sig_o !== 4'b0)  begin errors++; $display("FAIL reset sig_o got %b exp 0000", sig_o); end
    if (busy_o !== 4'b0) begin errors++; $display("FAIL reset busy_o got %b exp 0000", busy_o); end
    if (done_o !== 4'b0) begin errors++; $display("FAIL reset done_o got %b exp 0000", done_o); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_ch0_train(input string tag);
    int highs, busys, dones;
    highs = 0; busys = 0; dones = 0;
    count[0 +: W] = 8'd3; phi[0 +: W] = 8'd1; plow[0 +: W] = 8'd2; idle[0] = 1'b0;
    start[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); model_edge(); #1;
      start[0] = 1'b0;
      highs += int'(sig_o[0]); busys += int'(busy_o[0]); dones += int'(done_o[0]);
      checks += 3;
      if (sig_o !== m_sig)   begin errors++; $display("FAIL %s sig_o got %b exp %b", tag, sig_o, m_sig); end
      if (busy_o !== m_busy) begin errors++; $display("FAIL %s busy_o got %b exp %b", tag, busy_o, m_busy); end
      if (done_o !== m_done) begin errors++; $display("FAIL %s done_o got %b exp %b", tag, done_o, m_done); end
    end
    checks += 3;
    if (highs != 6)  begin errors++; $display("FAIL %s high_cycles got %0d exp 6", tag, highs); end
    if (busys != 15) begin errors++; $display("FAIL %s busy_cycles got %0d exp 15", tag, busys); end
    if (dones != 1)  begin errors++; $display("FAIL %s done_cycles got %0d exp 1", tag, dones); end
  endtask

  task automatic test_zero_count();
    count[1*W +: W] = 8'd0; phi[1*W +: W] = 8'd4; plow[1*W +: W] = 8'd4;
    start[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); model_edge(); #1;
      checks += 2;
      if (busy_o[1] !== 1'b0) begin errors++; $display("FAIL zero_count busy got %b exp 0", busy_o[1]); end
      if (done_o[1] !== (i == 0)) begin errors++; $display("FAIL zero_count done cyc%0d got %b exp %b", i, done_o[1], i == 0); end
      start[1] = 1'b0;
      checks += 3;
      if (sig_o !== m_sig)   begin errors++; $display("FAIL zero_count sig_o got %b exp %b", sig_o, m_sig); end
      if (busy_o !== m_busy) begin errors++; $display("FAIL zero_count busy_o got %b exp %b", busy_o, m_busy); end
      if (done_o !== m_done) begin errors++; $display("FAIL zero_count done_o got %b exp %b", done_o, m_done); end
    end
  endtask

  task automatic test_idle_high();
    logic [7:0] seq;
    logic [7:0] want;
    want = 8'b1111_1010;  // bit i = sig_o[2] after edge i: 0,1,0,1 then 1s
    seq = '0;
    count[2*W +: W] = 8'd2; phi[2*W +: W] = 8'd0; plow[2*W +: W] = 8'd0; idle[2] = 1'b1;
    start[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); model_edge(); #1;
      seq[i] = sig_o[2];
      start[2] = (i == 1);  // re-request mid-train
      checks += 3;
      if (sig_o !== m_sig)   begin errors++; $display("FAIL idle_high sig_o got %b exp %b", sig_o, m_sig); end
      if (busy_o !== m_busy) begin errors++; $display("FAIL idle_high busy_o got %b exp %b", busy_o, m_busy); end
      if (done_o !== m_done) begin errors++; $display("FAIL idle_high done_o got %b exp %b", done_o, m_done); end
    end
    checks++;
    if (seq !== want) begin errors++; $display("FAIL idle_high sequence got %b exp %b", seq, want); end
  endtask

  task automatic test_stop_long();
    int dones;
    dones = 0;
    count[3*W +: W] = 8'd255; phi[3*W +: W] = 8'd255; plow[3*W +: W] = 8'd255; idle[3] = 1'b1;
    start[3] = 1'b1;
    for (int i = 0; i < 1006; i++) begin
      @(posedge clock); model_edge(); #1;
      start[3] = 1'b0;
      count[3*W +: W] = W'($urandom);  // must not disturb the latched train
      stop[3] = (i == 999);
      dones += int'(done_o[3]);
      if (i == 1000) begin
        checks += 2;
        if (busy_o[3] !== 1'b0) begin errors++; $display("FAIL stop_long busy after stop got %b exp 0", busy_o[3]); end
        if (sig_o[3] !== 1'b1)  begin errors++; $display("FAIL stop_long sig after stop got %b exp 1", sig_o[3]); end
      end
      checks += 3;
      if (sig_o !== m_sig)   begin errors++; $display("FAIL stop_long sig_o got %b exp %b", sig_o, m_sig); end
      if (busy_o !== m_busy) begin errors++; $display("FAIL stop_long busy_o got %b exp %b", busy_o, m_busy); end
      if (done_o !== m_done) begin errors++; $display("FAIL stop_long done_o got %b exp %b", done_o, m_done); end
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL stop_long done_count got %0d exp 0", dones); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < C; n++) begin
        start[n] = ($urandom_range(3) == 0);
        stop[n]  = ($urandom_range(24) == 0);
        idle[n]  = $urandom_range(1);
        count[n*W +: W] = W'($urandom_range(3));
        phi[n*W +: W]   = W'($urandom_range(3));
        plow[n*W +: W]  = W'($urandom_range(3));
      end
      if (i == 599) stop = '1;
      @(posedge clock); model_edge(); #1;
      checks += 3;
      if (sig_o !== m_sig)   begin errors++; $display("FAIL random sig_o got %b exp %b", sig_o, m_sig); end
      if (busy_o !== m_busy) begin errors++; $display("FAIL random busy_o got %b exp %b", busy_o, m_busy); end
      if (done_o !== m_done) begin errors++; $display("FAIL random done_o got %b exp %b", done_o, m_done); end
    end
    clear_inputs();
    idle = m_idle;
  endtask

`ifdef PULSE_GEN_MC_CONT_EN
  task automatic test_cont();
    int toggles, dones;
    logic prev;
    toggles = 0; dones = 0;
    prev = sig_o[0];
    count[0 +: W] = 8'd2; phi[0 +: W] = 8'd0; plow[0 +: W] = 8'd0; idle[0] = 1'b0;
    cont_tb[0] = 1'b1; start[0] = 1'b1;
    for (int i = 0; i < 34; i++) begin
      @(posedge clock); model_edge(); #1;
      start[0] = 1'b0; cont_tb[0] = 1'b0;
      if (i < 30) begin
        toggles += int'(sig_o[0] != prev);
        dones   += int'(done_o[0]);
      end
      prev = sig_o[0];
      stop[0] = (i == 29);
      checks += 3;
      if (sig_o !== m_sig)   begin errors++; $display("FAIL cont sig_o got %b exp %b", sig_o, m_sig); end
      if (busy_o !== m_busy) begin errors++; $display("FAIL cont busy_o got %b exp %b", busy_o, m_busy); end
      if (done_o !== m_done) begin errors++; $display("FAIL cont done_o got %b exp %b", done_o, m_done); end
    end
    checks += 3;
    if (toggles <= 20) begin errors++; $display("FAIL cont toggles got %0d exp >20", toggles); end
    if (dones != 0)    begin errors++; $display("FAIL cont done_count got %0d exp 0", dones); end
    if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL cont busy after stop got %b exp 0", busy_o[0]); end
  endtask
`endif

  task automatic test_reset_mid();
    clear_inputs();
    for (int n = 0; n < C; n++) begin
      count[n*W +: W] = W'(5 + n); phi[n*W +: W] = W'(n + 2); plow[n*W +: W] = W'(3 - n);
    end
    idle = 4'b1010; start = '1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); model_edge(); #1;
      start = '0;
      checks += 3;
      if (sig_o !== m_sig)   begin errors++; $display("FAIL reset_mid sig_o got %b exp %b", sig_o, m_sig); end
      if (busy_o !== m_busy) begin errors++; $display("FAIL reset_mid busy_o got %b exp %b", busy_o, m_busy); end
      if (done_o !== m_done) begin errors++; $display("FAIL reset_mid done_o got %b exp %b", done_o, m_done); end
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks += 3;
    if (sig_o !== 4'b0)  begin errors++; $display("FAIL reset_mid async sig_o got %b exp 0000", sig_o); end
    if (busy_o !== 4'b0) begin errors++; $display("FAIL reset_mid async busy_o got %b exp 0000", busy_o); end
    if (done_o !== 4'b0) begin errors++; $display("FAIL reset_mid async done_o got %b exp 0000", done_o); end
    @(posedge clock); #3;
    reset = 1'b1;
    clear_inputs();
    @(posedge clock); model_edge(); #1;
    test_ch0_train("restart");
  endtask

  initial begin
    edge_n = 0;
    reset = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_ch0_train("ch0_train");
    test_zero_count();
    test_idle_high();
    test_stop_long();
    test_random();
`ifdef PULSE_GEN_MC_CONT_EN
    test_cont();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen_mc.md
PULSE_GEN_MC -- requirements
Module: pulse_gen_mc

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, bit width of pulse-count and phase-length fields.
REQ-002 Parameter CHANNELS SHALL be: CHANNELS, default 4, number of independent pulse channels.
REQ-003 Port clock SHALL be: clock  input  1  rising-edge clock for all state.
REQ-004 Port reset SHALL be: reset  input  1  asynchronous, active-low reset.
REQ-005 Port start SHALL be: start  input  CHANNELS  per-channel start request, sampled each rising edge.
REQ-006 Port stop SHALL be: stop  input  CHANNELS  per-channel abort request, sampled each rising edge.
REQ-007 Port count SHALL be: count  input  CHANNELS*WIDTH  pulses per train; channel n uses bits [n*WIDTH +: WIDTH].
REQ-008 Port phi SHALL be: phi  input  CHANNELS*WIDTH  active-phase length minus 1, per channel.
REQ-009 Port plow SHALL be: plow  input  CHANNELS*WIDTH  rest-phase length minus 1, per channel.
REQ-010 Port idle SHALL be: idle  input  CHANNELS  per-channel idle/rest output level.
REQ-011 Port sig_o SHALL be: sig_o  output  CHANNELS  registered pulse outputs.
REQ-012 Port busy_o SHALL be: busy_o  output  CHANNELS  registered; high while the channel is not in IDLE.
REQ-013 Port done_o SHALL be: done_o  output  CHANNELS  registered; one-cycle pulse on normal train completion.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, ACTIVE and REST; channels SHALL share no state.
REQ-015 In IDLE, start=1 and stop=0 SHALL latch count, phi, plow and idle into channel registers; later input changes SHALL NOT affect the running train.
REQ-016 In IDLE with start=1 and latched count=0, the channel SHALL stay in IDLE and assert done_o for the next cycle; sig_o SHALL not change.
REQ-017 In IDLE with start=1 and count>0, the next state SHALL be ACTIVE; sig_o=~idle and busy_o=1 SHALL be visible in the cycle after start is sampled.
REQ-018 ACTIVE SHALL last exactly phi+1 cycles with sig_o=~idle, then move to REST.
REQ-019 REST SHALL last exactly plow+1 cycles with sig_o=idle; the pulse counter SHALL decrement on REST entry.
REQ-020 REST end with pulse counter=0 SHALL go to IDLE with done_o=1 for exactly that first IDLE cycle; otherwise REST end SHALL go to ACTIVE.
REQ-021 Total busy time SHALL be count*(phi+plow+2) cycles; pulse and phase counters are WIDTH bits and SHALL NOT wrap.
REQ-022 start while busy_o=1 SHALL be ignored.
REQ-023 stop=1 in ACTIVE or REST SHALL force IDLE at the next edge, with sig_o=latched idle and done_o=0.
REQ-024 stop=1 together with start=1 in IDLE SHALL win: the start is dropped and no train runs.
REQ-025 In IDLE, sig_o SHALL hold the most recently latched idle value.

Reset
REQ-026 reset=0 SHALL immediately force all channels to IDLE, sig_o=0, busy_o=0, done_o=0, latched idle=0 and all counters=0, including mid-train.
REQ-027 The first start after reset release SHALL behave exactly as in REQ-015 to REQ-017.

Configuration
REQ-028 With PULSE_GEN_MC_CONT_EN defined, input port cont (CHANNELS bits) SHALL exist and be latched with start; when latched cont=1, REQ-020 reaching zero SHALL reload the latched count and continue at ACTIVE with no done_o, ending only on stop or reset.
REQ-029 Without PULSE_GEN_MC_CONT_EN, port cont SHALL be absent and every train SHALL end per REQ-020.

Verification
REQ-030 Ch0 count=3, phi=1, plow=2, idle=0, start for 1 cycle -> sig_o[0] high 2 cycles and low 3 cycles, three times; busy 15 cycles; done_o[0] for 1 cycle; other channels quiet.
REQ-031 Ch1 count=0, start -> busy_o[1] stays 0; done_o[1] pulses 1 cycle in the next cycle.
REQ-032 Ch2 idle=1, count=2, phi=0, plow=0 -> sig_o[2] sequence 0,1,0,1, then stays 1; start re-asserted mid-train is ignored.
REQ-033 Ch3 count=255, phi=255, plow=255, stop asserted at cycle 1000 -> IDLE at next edge, sig_o=idle, done_o never asserted.
REQ-034 All channels started with different settings, reset=0 asserted mid-train -> all outputs 0 immediately; a restart after release matches REQ-030.
REQ-035 With PULSE_GEN_MC_CONT_EN, cont=1, count=2, phi=0, plow=0 -> sig_o toggles continuously for more than 20 cycles with no done_o, and stops on stop.
